// File: rtl/mem_fill_pkg.sv
// Shared types and derived-constant helpers for the block-fill memory arbiter.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    RESP
  } state_e;

  function automatic int unsigned calc_words(input int unsigned block_size,
                                             input int unsigned bus_width);
    return block_size / bus_width;
  endfunction

  function automatic int unsigned calc_offset_bits(input int unsigned block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int unsigned calc_wshift(input int unsigned bus_width);
    return $clog2(bus_width / 8);
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

  function automatic int unsigned calc_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester above the last grant, with wrap.
module rr_arbiter
  import mem_fill_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W = calc_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic found;

  // Constant-index double loop keeps every select static.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      for (int unsigned q = 0; q < NUM_PORTS; q++) begin
        if (!found && req_i[q] && ((32'(last_i) + k) % NUM_PORTS == q)) begin
          grant_o[q] = 1'b1;
          idx_o      = IDX_W'(q);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Round-robin block requester arbiter moving one cacheline per transaction
// over a narrow external word bus.
module mem_fill_arbiter
  import mem_fill_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned BLOCK_SIZE     = 256
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [NUM_PORTS-1:0]            reqValid_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] reqAddress_i,
  input  logic [NUM_PORTS-1:0]            reqIsWrite_i,
  input  logic [NUM_PORTS*BLOCK_SIZE-1:0] reqBlock_i,
  output logic [NUM_PORTS-1:0]            reqReady_o,
  input  logic                            flush_i,
  output logic [NUM_PORTS-1:0]            respValid_o,
  output logic [ADDR_WIDTH-1:0]           respAddress_o,
  output logic [BLOCK_SIZE-1:0]           respBlock_o,
  output logic                            busy_o,
  output logic                            memRequest_o,
  output logic                            memIsWrite_o,
  output logic [MEM_ADDR_WIDTH-1:0]       memAddress_o,
  output logic [BUS_WIDTH-1:0]            memData_o,
  input  logic [BUS_WIDTH-1:0]            memData_i,
  input  logic                            memValid_i
);

  localparam int unsigned WORDS       = calc_words(BLOCK_SIZE, BUS_WIDTH);
  localparam int unsigned OFFSET_BITS = calc_offset_bits(BLOCK_SIZE);
  localparam int unsigned WSHIFT      = calc_wshift(BUS_WIDTH);
  localparam int unsigned CNT_W       = calc_cnt_width(WORDS);
  localparam int unsigned IDX_W       = calc_idx_width(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  state_e                    state_q;
  logic [IDX_W-1:0]          port_q;
  logic [IDX_W-1:0]          lastGrant_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      isWrite_q;
  logic [BLOCK_SIZE-1:0]     block_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      discard_q;

  logic [NUM_PORTS-1:0]      grant_d;
  logic [IDX_W-1:0]          grantIdx_d;
  logic                      accept_d;
  logic                      readFlush_d;
  logic                      lastWord_d;
  logic [ADDR_WIDTH-1:0]     selAddr_d;
  logic [ADDR_WIDTH-1:0]     alignedAddr_d;
  logic [BLOCK_SIZE-1:0]     selBlock_d;
  logic                      selWrite_d;
  logic [BUS_WIDTH-1:0]      inWord_d;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_arbiter (
    .req_i  (reqValid_i),
    .last_i (lastGrant_q),
    .grant_o(grant_d),
    .idx_o  (grantIdx_d)
  );

  always_comb begin
    selAddr_d  = '0;
    selBlock_d = '0;
    selWrite_d = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_d[p]) begin
        selAddr_d  = reqAddress_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        selBlock_d = reqBlock_i[p*BLOCK_SIZE +: BLOCK_SIZE];
        selWrite_d = reqIsWrite_i[p];
      end
    end
  end

  assign alignedAddr_d = selAddr_d & ~OFFSET_MASK;
  assign accept_d      = (state_q == IDLE) && !reset_i && !flush_i && (|reqValid_i);
  assign readFlush_d   = flush_i && !isWrite_q;
  assign lastWord_d    = (cnt_q == CNT_W'(WORDS - 1));
  // Writes rotate the latched block so the outgoing word is always on top and the
  // original block is restored after WORDS beats; reads shift the incoming word in.
  assign inWord_d      = isWrite_q ? block_q[BLOCK_SIZE-1 -: BUS_WIDTH] : memData_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      port_q      <= '0;
      lastGrant_q <= IDX_W'(NUM_PORTS - 1);
      addr_q      <= '0;
      isWrite_q   <= 1'b0;
      block_q     <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            port_q    <= grantIdx_d;
            addr_q    <= alignedAddr_d;
            isWrite_q <= selWrite_d;
            block_q   <= selBlock_d;
            base_q    <= MEM_ADDR_WIDTH'(alignedAddr_d >> WSHIFT);
            cnt_q     <= '0;
            discard_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (readFlush_d) discard_q <= 1'b1;
          state_q <= XFER;
        end
        XFER: begin
          if (readFlush_d) discard_q <= 1'b1;
          if (memValid_i) begin
            block_q <= (block_q << BUS_WIDTH) | BLOCK_SIZE'(inWord_d);
            cnt_q   <= cnt_q + CNT_W'(1);
            if (lastWord_d) state_q <= RESP;
          end
        end
        RESP: begin
          lastGrant_q <= port_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady_o    = accept_d ? grant_d : '0;
  assign busy_o        = (state_q != IDLE);
  assign memRequest_o  = (state_q == ISSUE);
  assign memIsWrite_o  = ((state_q == ISSUE) || (state_q == XFER)) && isWrite_q;
  assign memAddress_o  = ((state_q == ISSUE) || (state_q == XFER))
                         ? base_q + MEM_ADDR_WIDTH'(cnt_q) : '0;
  assign memData_o     = ((state_q == XFER) && isWrite_q) ? block_q[BLOCK_SIZE-1 -: BUS_WIDTH] : '0;
  assign respValid_o   = ((state_q == RESP) && !discard_q && !readFlush_d)
                         ? (NUM_PORTS'(1) << port_q) : '0;
  assign respAddress_o = (state_q == RESP) ? addr_q : '0;
  assign respBlock_o   = (state_q == RESP) ? block_q : '0;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench: cycle model of the arbiter plus directed transactions.
module tb_mem_fill_arbiter;

  localparam int NP = 2, AW = 64, MAW = 16, BW = 32, BS = 256, W = 8;

  logic             clk, rst, flush, memValid_i;
  logic [NP-1:0]    reqValid_i, reqIsWrite_i, reqReady_o, respValid_o;
  logic [NP*AW-1:0] reqAddress_i;
  logic [NP*BS-1:0] reqBlock_i;
  logic [AW-1:0]    respAddress_o;
  logic [BS-1:0]    respBlock_o;
  logic             busy_o, memRequest_o, memIsWrite_o;
  logic [MAW-1:0]   memAddress_o;
  logic [BW-1:0]    memData_o, memData_i;

  mem_fill_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .BUS_WIDTH(BW), .BLOCK_SIZE(BS)
  ) dut (
    .clock_i(clk), .reset_i(rst), .reqValid_i(reqValid_i), .reqAddress_i(reqAddress_i),
    .reqIsWrite_i(reqIsWrite_i), .reqBlock_i(reqBlock_i), .reqReady_o(reqReady_o),
    .flush_i(flush), .respValid_o(respValid_o), .respAddress_o(respAddress_o),
    .respBlock_o(respBlock_o), .busy_o(busy_o), .memRequest_o(memRequest_o),
    .memIsWrite_o(memIsWrite_o), .memAddress_o(memAddress_o), .memData_o(memData_o),
    .memData_i(memData_i), .memValid_i(memValid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Logs shared between processes
  int           acc_port[$], acc_cyc[$], rsp_cyc[$];
  logic [1:0]   rsp_val[$];
  logic [63:0]  rsp_addr[$];
  logic [255:0] rsp_blk[$];
  logic [15:0]  strq[$], alog[$];
  logic [31:0]  wlog[$];
  logic [NP-1:0] acc_mask = '0;
  logic [31:0]  rd_words[W];
  bit           gap = 0;

  // Behavioural model state
  bit           m_active = 0, m_wr = 0, m_disc = 0;
  int           m_since = 0, m_words = 0, m_port = 0, m_last = NP - 1;
  logic [63:0]  m_addr = '0;
  logic [255:0] m_blk = '0;

  function automatic int pick(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++) begin
      int q;
      q = (last + k) % NP;
      if (v[q]) return q;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NP-1:0] exp_ready, exp_rv;
    bit iss, xf, rs;
    int p;
    if (cyc >= 1) begin
      exp_ready = '0;
      p = pick(reqValid_i, m_last);
      if (!rst && !m_active && !flush && p >= 0) exp_ready[p] = 1'b1;
      iss = m_active && (m_since == 1);
      xf  = m_active && (m_since > 1) && (m_words < W);
      rs  = m_active && (m_words == W);
      exp_rv = '0;
      if (rs && !m_disc && !(flush && !m_wr)) exp_rv[m_port] = 1'b1;
      chk("reqReady", reqReady_o, exp_ready);
      chk("busy", busy_o, m_active);
      chk("memRequest", memRequest_o, iss);
      chk("memIsWrite", memIsWrite_o, (iss || xf) && m_wr);
      chk("memAddress", memAddress_o, (iss || xf) ? 16'(m_addr >> 2) + 16'(m_words) : 16'h0);
      chk("memData", memData_o, (xf && m_wr) ? m_blk[255-32*m_words -: 32] : 32'h0);
      chk("respValid", respValid_o, exp_rv);
      chk("respAddress", respAddress_o, rs ? m_addr : 64'h0);
      chk("respBlock", respBlock_o, rs ? m_blk : 256'h0);
      acc_mask = reqValid_i & reqReady_o;
      if (respValid_o != '0) begin
        rsp_cyc.push_back(cyc); rsp_val.push_back(respValid_o);
        rsp_addr.push_back(respAddress_o); rsp_blk.push_back(respBlock_o);
      end
      // advance the model across the coming edge
      if (rst) begin
        m_active = 0; m_last = NP - 1;
      end else if (!m_active) begin
        if (exp_ready != '0) begin
          m_active = 1; m_since = 1; m_words = 0; m_disc = 0; m_port = p;
          m_addr = reqAddress_i[p*AW +: AW] & ~64'h1F;
          m_wr   = reqIsWrite_i[p];
          m_blk  = m_wr ? reqBlock_i[p*BS +: BS] : '0;
          acc_port.push_back(p); acc_cyc.push_back(cyc);
        end
      end else begin
        if (flush && !m_wr) m_disc = 1;
        if (rs) begin
          m_last = m_port; m_active = 0;
        end else begin
          if (xf && memValid_i) begin
            if (!m_wr) m_blk[255-32*m_words -: 32] = memData_i;
            m_words++;
          end
          m_since++;
        end
      end
    end
  end

  // External memory responder: one word per valid beat, optional alternate-cycle gaps
  initial begin
    int  k;
    bit  tog, v;
    memValid_i = 1'b0; memData_i = '0;
    forever begin
      @(posedge clk); #1;
      if (memRequest_o === 1'b1 && !rst) begin
        strq.push_back(memAddress_o);
        k = 0; tog = 0;
        @(posedge clk); #1;
        while (k < W && !rst) begin
          v = gap ? tog : 1'b1;
          tog = !tog;
          memValid_i = v;
          memData_i  = v ? rd_words[k] : '0;
          @(negedge clk);
          if (v && !rst) begin
            alog.push_back(memAddress_o); wlog.push_back(memData_o); k++;
          end
          @(posedge clk); #1;
        end
        memValid_i = 1'b0; memData_i = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    reqValid_i = reqValid_i & ~acc_mask;
  endtask

  task automatic set_req(input int p, input logic [63:0] a, input bit wr, input logic [255:0] blk);
    reqAddress_i[p*AW +: AW] = a;
    reqIsWrite_i[p]          = wr;
    reqBlock_i[p*BS +: BS]   = blk;
    reqValid_i[p]            = 1'b1;
  endtask

  task automatic clear_logs();
    acc_port.delete(); acc_cyc.delete(); rsp_cyc.delete(); rsp_val.delete();
    rsp_addr.delete(); rsp_blk.delete(); strq.delete(); alog.delete(); wlog.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    tick();
    while ((reqValid_i != '0 || busy_o) && n < 400) begin
      tick(); n++;
    end
    chk({nm, "_done"}, n < 400, 1'b1);
    tick();
  endtask

  localparam logic [255:0] RD_BLK = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] WR_BLK = 256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7;
  localparam logic [255:0] GP_BLK = 256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007;

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; reqValid_i = '0; reqIsWrite_i = '0;
    reqAddress_i = '0; reqBlock_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_respValid", respValid_o, 2'b00);
    chk("rst_memRequest", memRequest_o, 1'b0);
    tick();

    // single read on port 0
    for (int i = 0; i < W; i++) rd_words[i] = 32'h11111111 * (i + 1);
    clear_logs();
    set_req(0, 64'h1234, 1'b0, '0);
    wait_idle("read");
    chk("rd_nstrobe", strq.size(), 1);
    if (strq.size() == 1) chk("rd_strobe_addr", strq[0], 16'h0488);
    chk("rd_nwords", alog.size(), W);
    if (alog.size() == W) for (int i = 0; i < W; i++) chk("rd_word_addr", alog[i], 16'h0488 + 16'(i));
    chk("rd_nresp", rsp_val.size(), 1);
    if (rsp_val.size() == 1 && acc_cyc.size() == 1) begin
      chk("rd_latency", rsp_cyc[0] - acc_cyc[0], 10);
      chk("rd_respValid", rsp_val[0], 2'b01);
      chk("rd_respAddr", rsp_addr[0], 64'h1220);
      chk("rd_respBlock", rsp_blk[0], RD_BLK);
    end

    // write on port 1
    clear_logs();
    set_req(1, 64'h205C, 1'b1, WR_BLK);
    wait_idle("write");
    if (strq.size() == 1) chk("wr_strobe_addr", strq[0], 16'h0810);
    chk("wr_nwords", wlog.size(), W);
    if (wlog.size() == W) for (int i = 0; i < W; i++) chk("wr_word", wlog[i], 32'hA0 + 32'(i));
    chk("wr_nresp", rsp_val.size(), 1);
    if (rsp_val.size() == 1) begin
      chk("wr_respValid", rsp_val[0], 2'b10);
      chk("wr_respAddr", rsp_addr[0], 64'h2040);
      chk("wr_respBlock", rsp_blk[0], WR_BLK);
    end

    // contention, twice back-to-back
    clear_logs();
    set_req(0, 64'h100, 1'b0, '0); set_req(1, 64'h200, 1'b0, '0);
    wait_idle("cont1");
    set_req(0, 64'h100, 1'b0, '0); set_req(1, 64'h200, 1'b0, '0);
    wait_idle("cont2");
    chk("cont_ngrants", acc_port.size(), 4);
    if (acc_port.size() == 4) for (int i = 0; i < 4; i++) chk("cont_grant", acc_port[i], i % 2);

    // flushed read after three words
    clear_logs();
    set_req(0, 64'h3000, 1'b0, '0);
    n = 0;
    while (alog.size() < 3 && n < 100) begin tick(); n++; end
    chk("fl_reach3", n < 100, 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_idle("flush");
    chk("fl_nresp", rsp_val.size(), 0);
    chk("fl_nwords", alog.size(), W);
    if (alog.size() == W) chk("fl_last_addr", alog[W-1], 16'h0C07);
    clear_logs();
    flush = 1'b1;
    set_req(1, 64'h4000, 1'b0, '0);
    tick();
    chk("fl_idle_block", acc_port.size(), 0);
    flush = 1'b0;
    wait_idle("after_flush");
    if (acc_port.size() == 1) chk("fl_next_port", acc_port[0], 1);
    if (rsp_val.size() == 1) chk("fl_next_resp", rsp_val[0], 2'b10);

    // gapped memValid with address truncation
    for (int i = 0; i < W; i++) rd_words[i] = 32'hC0DE0000 + 32'(i);
    gap = 1;
    clear_logs();
    set_req(1, 64'h1_0003_FFE5, 1'b0, '0);
    wait_idle("gap");
    gap = 0;
    if (strq.size() == 1) chk("gp_strobe_addr", strq[0], 16'hFFF8);
    chk("gp_nwords", alog.size(), W);
    if (alog.size() == W) for (int i = 0; i < W; i++) chk("gp_word_addr", alog[i], 16'hFFF8 + 16'(i));
    if (rsp_val.size() == 1 && acc_cyc.size() == 1) begin
      chk("gp_latency", rsp_cyc[0] - acc_cyc[0], 18);
      chk("gp_respValid", rsp_val[0], 2'b10);
      chk("gp_respAddr", rsp_addr[0], 64'h1_0003_FFE0);
      chk("gp_respBlock", rsp_blk[0], GP_BLK);
    end else chk("gp_nresp", rsp_val.size(), 1);

    // port 0 read, then abort a port 1 read with reset mid-transfer
    clear_logs();
    set_req(0, 64'h80, 1'b0, '0);
    wait_idle("p0");
    if (acc_port.size() == 1) chk("p0_port", acc_port[0], 0);
    clear_logs();
    set_req(1, 64'h500, 1'b0, '0);
    n = 0;
    while (alog.size() < 2 && n < 100) begin tick(); n++; end
    chk("ab_reach2", n < 100, 1'b1);
    rst = 1'b1;
    tick();
    chk("ab_busy", busy_o, 1'b0);
    chk("ab_memRequest", memRequest_o, 1'b0);
    chk("ab_respValid", respValid_o, 2'b00);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("ab_nresp", rsp_val.size(), 0);
    clear_logs();
    set_req(0, 64'h600, 1'b0, '0); set_req(1, 64'h700, 1'b0, '0);
    wait_idle("post_reset");
    chk("pr_ngrants", acc_port.size(), 2);
    if (acc_port.size() == 2) begin
      chk("pr_first", acc_port[0], 0);
      chk("pr_second", acc_port[1], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
